// File: rtl/mem_rmw_maxpool.sv
// mem_rmw_maxpool: read-modify-write front end for the dual-port feature memory.
// Each accepted update (address, feature vector) reads the stored vector on port A,
// takes the lane-wise unsigned maximum and writes it back on port B, one update per
// cycle. The read latency is hidden by forwarding from the two write stages.
// Optional full-memory clear sweep, compiled in when MEM_RMW_CLEAR_EN is defined.
//
// Ports:
//   i_clk, i_rst          clock, asynchronous active-high reset
//   i_s_valid, o_s_ready  update handshake; i_s_addr / i_s_data carry the update
//   i_clr_start           one-cycle clear request; o_clr_busy high while it is pending/running
//   o_mem_ena, o_addra    port A read request; i_douta returns data one cycle later
//   o_mem_enb, o_web      port B write enable (always equal)
//   o_addrb, o_dinb       port B write address / data
module mem_rmw_maxpool #(
  parameter int unsigned AWIDTH = 16,
  parameter int unsigned DWIDTH = 72,
  parameter int unsigned LANES  = 8
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_s_valid,
  output logic              o_s_ready,
  input  logic [AWIDTH-1:0] i_s_addr,
  input  logic [DWIDTH-1:0] i_s_data,
  input  logic              i_clr_start,
  output logic              o_clr_busy,
  output logic              o_mem_ena,
  output logic [AWIDTH-1:0] o_addra,
  input  logic [DWIDTH-1:0] i_douta,
  output logic              o_mem_enb,
  output logic              o_web,
  output logic [AWIDTH-1:0] o_addrb,
  output logic [DWIDTH-1:0] o_dinb
);
  localparam int unsigned LW = DWIDTH / LANES;

  logic              r_s_ready;
  logic              r_v1, r_v2, r_v3;
  logic [AWIDTH-1:0] r_a1, r_a2, r_a3;
  logic [DWIDTH-1:0] r_d1, r_d2, r_d3;

  logic              w_hs;
  logic              w_ready_d;
  logic              w_v3_d;
  logic [DWIDTH-1:0] w_opnd;
  logic [DWIDTH-1:0] w_max;

  assign w_hs      = i_s_valid & r_s_ready;
  assign o_s_ready = r_s_ready;
  assign o_mem_ena = w_hs;
  assign o_addra   = w_hs ? i_s_addr : '0;

  // Newest matching in-flight write wins; stage 3 covers the write the memory
  // committed on the same edge as our read and therefore did not return.
  always_comb begin
    if (r_v2 && (r_a1 == r_a2)) begin
      w_opnd = r_d2;
    end else if (r_v3 && (r_a1 == r_a3)) begin
      w_opnd = r_d3;
    end else begin
      w_opnd = i_douta;
    end
  end

  always_comb begin
    w_max = '0;
    for (int i = 0; i < int'(LANES); i++) begin
      w_max[i*LW +: LW] = (r_d1[i*LW +: LW] > w_opnd[i*LW +: LW]) ?
                          r_d1[i*LW +: LW] : w_opnd[i*LW +: LW];
    end
  end

`ifdef MEM_RMW_CLEAR_EN
  typedef enum logic [1:0] {StRun, StDrain, StClear} state_e;

  state_e            r_state, w_state_d;
  logic [AWIDTH-1:0] r_cnt;
  logic              r_clr_busy;
  logic              w_in_clear;
  logic              w_to_clear;

  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      StRun:   if (i_clr_start) w_state_d = StDrain;
      StDrain: if (!r_v1 && !r_v2) w_state_d = StClear;
      StClear: if (&r_cnt) w_state_d = StRun;
      default: w_state_d = StRun;
    endcase
  end

  assign w_in_clear = (r_state == StClear);
  assign w_to_clear = (r_state == StDrain) && (w_state_d == StClear);
  assign w_ready_d  = (w_state_d == StRun);
  assign w_v3_d     = r_v2 & ~w_to_clear;
  assign o_clr_busy = r_clr_busy;

  always_comb begin
    o_mem_enb = r_v2;
    o_addrb   = r_v2 ? r_a2 : '0;
    o_dinb    = r_v2 ? r_d2 : '0;
    if (w_in_clear) begin
      o_mem_enb = 1'b1;
      o_addrb   = r_cnt;
      o_dinb    = '0;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state    <= StRun;
      r_cnt      <= '0;
      r_clr_busy <= 1'b0;
    end else begin
      r_state    <= w_state_d;
      r_clr_busy <= (w_state_d != StRun);
      if (w_to_clear) begin
        r_cnt <= '0;
      end else if (w_in_clear) begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end
`else
  logic w_unused_clr;

  assign w_unused_clr = i_clr_start;
  assign w_ready_d    = 1'b1;
  assign w_v3_d       = r_v2;
  assign o_clr_busy   = 1'b0;
  assign o_mem_enb    = r_v2;
  assign o_addrb      = r_v2 ? r_a2 : '0;
  assign o_dinb       = r_v2 ? r_d2 : '0;
`endif

  assign o_web = o_mem_enb;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_s_ready <= 1'b0;
      r_v1      <= 1'b0;
      r_v2      <= 1'b0;
      r_v3      <= 1'b0;
      r_a1      <= '0;
      r_a2      <= '0;
      r_a3      <= '0;
      r_d1      <= '0;
      r_d2      <= '0;
      r_d3      <= '0;
    end else begin
      r_s_ready <= w_ready_d;
      r_v1      <= w_hs;
      if (w_hs) begin
        r_a1 <= i_s_addr;
        r_d1 <= i_s_data;
      end
      r_v2 <= r_v1;
      if (r_v1) begin
        r_a2 <= r_a1;
        r_d2 <= w_max;
      end
      r_v3 <= w_v3_d;
      r_a3 <= r_a2;
      r_d3 <= r_d2;
    end
  end

endmodule

// File: tb/tb_mem_rmw_maxpool.sv
// Bench for mem_rmw_maxpool with AWIDTH=4 and a behavioural dual-port memory.
// Clear and reset-mid-clear sequences run only when MEM_RMW_CLEAR_EN is defined.
module tb_mem_rmw_maxpool;
  localparam int AW = 4;
  localparam int DW = 72;
  localparam int NL = 8;
  localparam int LW = 9;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          s_valid = 1'b0;
  logic          s_ready;
  logic [AW-1:0] s_addr = '0;
  logic [DW-1:0] s_data = '0;
  logic          clr = 1'b0;
  logic          clr_busy;
  logic          mem_ena;
  logic [AW-1:0] addra;
  logic [DW-1:0] douta_q;
  logic          mem_enb;
  logic          web;
  logic [AW-1:0] addrb;
  logic [DW-1:0] dinb;

  logic          tb_init = 1'b1;
  logic [DW-1:0] mem [16];
  int            cyc = 0;
  int            checks = 0;
  int            errors = 0;

  typedef struct {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    int            c;
    logic          w;
  } wr_t;
  wr_t wq[$];

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic [DW-1:0] exp;
  } vec_t;
  vec_t vecs[11];
  int   hs_cyc[11];

  mem_rmw_maxpool #(.AWIDTH(AW), .DWIDTH(DW), .LANES(NL)) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_s_valid   (s_valid),
    .o_s_ready   (s_ready),
    .i_s_addr    (s_addr),
    .i_s_data    (s_data),
    .i_clr_start (clr),
    .o_clr_busy  (clr_busy),
    .o_mem_ena   (mem_ena),
    .o_addra     (addra),
    .i_douta     (douta_q),
    .o_mem_enb   (mem_enb),
    .o_web       (web),
    .o_addrb     (addrb),
    .o_dinb      (dinb)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [DW-1:0] rep(input logic [LW-1:0] v);
    logic [DW-1:0] r;
    for (int i = 0; i < NL; i++) r[i*LW +: LW] = v;
    return r;
  endfunction

  function automatic logic [DW-1:0] alt(input logic [LW-1:0] a, input logic [LW-1:0] b);
    logic [DW-1:0] r;
    for (int i = 0; i < NL; i++) r[i*LW +: LW] = (i % 2 == 0) ? a : b;
    return r;
  endfunction

  function automatic logic [DW-1:0] lane0(input logic [LW-1:0] v);
    logic [DW-1:0] r;
    r = '0;
    r[LW-1:0] = v;
    return r;
  endfunction

  // Memory: synchronous read on A, write on B; a same-edge read returns old data.
  always @(posedge clk) begin
    if (tb_init) begin
      for (int i = 0; i < 16; i++) mem[i] <= '0;
      mem[7] <= alt(9'd1, 9'd9);
    end else if (mem_enb && web) begin
      mem[addrb] <= dinb;
    end
    if (mem_ena) douta_q <= mem[addra];
  end

  always @(negedge clk) begin
    if (mem_enb) wq.push_back('{a: addrb, d: dinb, c: cyc, w: web});
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Called just after a posedge; returns just after the accepting posedge.
  task automatic send(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic c,
                      output int hs);
    int n;
    n = 0;
    hs = -1;
    s_valid = 1'b1;
    s_addr = a;
    s_data = d;
    clr = c;
    forever begin
      @(negedge clk);
      if (s_ready) break;
      n++;
      if (n > 20) break;
    end
    chk("send_ready", s_ready, 1);
    if (s_ready) begin
      hs = cyc;
      chk("porta_ena", mem_ena, 1);
      chk("porta_addr", addra, a);
    end
    @(posedge clk);
    #1;
    s_valid = 1'b0;
    clr = 1'b0;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_ready"}, s_ready, 0);
    chk({tag, "_busy"}, clr_busy, 0);
    chk({tag, "_ena"}, mem_ena, 0);
    chk({tag, "_addra"}, addra, 0);
    chk({tag, "_enb"}, mem_enb, 0);
    chk({tag, "_web"}, web, 0);
    chk({tag, "_addrb"}, addrb, 0);
    chk({tag, "_dinb"}, dinb, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int h;
    int bad;
    int n;

    vecs[0]  = '{addr: 4'd3, data: rep(9'h005),      exp: rep(9'h005)};
    vecs[1]  = '{addr: 4'd7, data: rep(9'h005),      exp: alt(9'd5, 9'd9)};
    vecs[2]  = '{addr: 4'd0, data: rep(9'h1FF),      exp: rep(9'h1FF)};
    vecs[3]  = '{addr: 4'd2, data: lane0(9'd4),      exp: lane0(9'd4)};
    vecs[4]  = '{addr: 4'd2, data: lane0(9'd2),      exp: lane0(9'd4)};
    vecs[5]  = '{addr: 4'd2, data: lane0(9'd7),      exp: lane0(9'd7)};
    vecs[6]  = '{addr: 4'd5, data: lane0(9'd6),      exp: lane0(9'd6)};
    vecs[7]  = '{addr: 4'd9, data: lane0(9'd1),      exp: lane0(9'd1)};
    vecs[8]  = '{addr: 4'd5, data: lane0(9'd3),      exp: lane0(9'd6)};
    vecs[9]  = '{addr: 4'd0, data: rep(9'h000),      exp: rep(9'h1FF)};
    vecs[10] = '{addr: 4'd3, data: alt(9'd2, 9'd7),  exp: alt(9'd5, 9'd7)};

    // Reset state
    repeat (2) @(negedge clk);
    tb_init = 1'b0;
    chk_reset_outputs("reset");
    rst = 1'b0;
    #1;
    chk("ready_before_first_edge", s_ready, 0);
    @(posedge clk);
    #1;
    chk("ready_after_first_edge", s_ready, 1);
    wq.delete();

    // Back-to-back burst from the vector table
    for (int i = 0; i < 11; i++) begin
      send(vecs[i].addr, vecs[i].data, 1'b0, hs_cyc[i]);
    end
    repeat (4) @(posedge clk);
    #1;
    chk("burst_write_count", wq.size(), 11);
    for (int i = 0; i < 11; i++) begin
      if (i < wq.size()) begin
        chk($sformatf("vec%0d_addrb", i), wq[i].a, vecs[i].addr);
        chk($sformatf("vec%0d_dinb", i), wq[i].d, vecs[i].exp);
        chk($sformatf("vec%0d_latency", i), wq[i].c - hs_cyc[i], 2);
        chk($sformatf("vec%0d_web", i), wq[i].w, 1);
      end
    end
    chk("mem2_lane0_final", mem[2][LW-1:0], 7);
    chk("mem5_lane0_final", mem[5][LW-1:0], 6);

`ifdef MEM_RMW_CLEAR_EN
    // Clear with two updates in flight; clr_start coincides with the second one.
    wq.delete();
    send(4'd1, rep(9'd3), 1'b0, h);
    send(4'd4, rep(9'd8), 1'b1, h);
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      #1;
      if (!(s_ready == 1'b0 && clr_busy == 1'b1)) bad++;
      if (wq.size() >= 18) break;
    end
    chk("clear_hold_bad_cycles", bad, 0);
    chk("clear_write_count", wq.size(), 18);
    @(posedge clk);
    #1;
    chk("clear_done_busy", clr_busy, 0);
    chk("clear_done_ready", s_ready, 1);
    if (wq.size() >= 18) begin
      chk("clear_upd0_addr", wq[0].a, 1);
      chk("clear_upd0_data", wq[0].d, rep(9'd3));
      chk("clear_upd1_addr", wq[1].a, 4);
      chk("clear_upd1_data", wq[1].d, rep(9'd8));
      bad = 0;
      for (int k = 0; k < 16; k++) begin
        if (wq[2+k].a !== 4'(k) || wq[2+k].d !== '0 || wq[2+k].w !== 1'b1) bad++;
      end
      chk("clear_sweep_bad_writes", bad, 0);
      chk("clear_sweep_span", wq[17].c - wq[2].c, 15);
    end
    wq.delete();
    send(4'd3, rep(9'd1), 1'b0, h);
    repeat (4) @(posedge clk);
    #1;
    chk("post_clear_count", wq.size(), 1);
    if (wq.size() >= 1) begin
      chk("post_clear_addr", wq[0].a, 3);
      chk("post_clear_data", wq[0].d, rep(9'd1));
    end

    // Reset while the sweep is writing address 8
    clr = 1'b1;
    @(posedge clk);
    #1;
    clr = 1'b0;
    n = 0;
    forever begin
      @(negedge clk);
      if (mem_enb && addrb == 4'd8) break;
      n++;
      if (n > 100) break;
    end
    chk("sweep_reached_addr8", addrb, 8);
    rst = 1'b1;
    #1;
    chk_reset_outputs("midclear_rst");
    wq.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("midclear_ready_at_release", s_ready, 0);
    @(posedge clk);
    #1;
    chk("midclear_ready_after_edge", s_ready, 1);
    chk("midclear_busy_after_edge", clr_busy, 0);
    repeat (20) @(posedge clk);
    #1;
    chk("midclear_no_more_writes", wq.size(), 0);
`else
    // Without the clear feature clr_start has no effect.
    wq.delete();
    clr = 1'b1;
    @(posedge clk);
    #1;
    clr = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("noclr_ready", s_ready, 1);
    chk("noclr_busy", clr_busy, 0);
    chk("noclr_no_writes", wq.size(), 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
